bus_cycle_ctrl: RTL and testbench
=================================

// Module: bus_cycle_ctrl
// PURPOSE
//   Bus-cycle controller for the peripheral data-bus buffer stage.
//   - Synchronizes the external host strobes and generates the IWR/IRD controls for the buffer.
//   - Consumes the buffer's InternalBus and commits completed host writes into a 3-entry register file.
//   - Exposes a read-only status register at address 3.
// PARAMETERS
//   SYNC_STAGES     2    flops per synchronizer on CS_n/RD_n/WR_n/A (legal values 2..3)
//   TIMEOUT_CYCLES  255  max cycles in WRITE/READ before abort (used only with the macro)
// PORTS
//   CLK          in   1  system clock, rising edge
//   RST          in   1  asynchronous reset, active-low
//   CS_n         in   1  host chip select, active-low, asynchronous to CLK
//   RD_n         in   1  host read strobe, active-low, asynchronous
//   WR_n         in   1  host write strobe, active-low, asynchronous
//   A            in   2  host register address, asynchronous
//   InternalBus  in   8  captured byte from the bus buffer register
//   IWR          out  1  internal write enable to the buffer (buffer captures DataBus)
//   IRD          out  1  internal read enable to the buffer (buffer drives DataBus)
//   Reg0..Reg2   out  8  register file contents (three separate ports)
//   WrStrobe     out  1  1-cycle pulse when a write commits
//   RdStrobe     out  1  1-cycle pulse at the start of a read cycle
//   RdAddr       out  2  address latched for the current read; valid while IRD=1
//   ErrFlag      out  1  sticky flag: RD_n and WR_n both low with CS_n low
//   TimeoutFlag  out  1  sticky flag: cycle aborted by timeout
//   WrCount      out  8  count of committed writes
// BEHAVIOUR
//   Reset (RST=0, async):
//   - All outputs 0; Reg0..2=0; WrCount=0; FSM=IDLE.
//   - Synchronizer flops reset to 1 on strobes and 0 on A.
//   Naming: cs/rd/wr below are the synchronized active-high strobes. Input-to-FSM latency is SYNC_STAGES cycles.
//   IDLE:
//   - cs&wr&!rd  -> WRITE; latch A.
//   - cs&rd&!wr  -> READ; latch A into RdAddr; RdStrobe=1 for 1 cycle.
//   - cs&rd&wr   -> stay in IDLE; set ErrFlag.
//   WRITE:
//   - IWR=1 on every cycle in this state.
//   - !wr | !cs  -> COMMIT.
//   COMMIT (exactly 1 cycle, IWR=0):
//   - Latched A in 0..2: Reg[A] <= InternalBus.
//   - Latched A = 3: a 1 on InternalBus[0] clears ErrFlag; InternalBus[1] clears TimeoutFlag.
//   - WrStrobe=1; WrCount+1, wrapping 255->0; -> IDLE.
//   READ:
//   - IRD=1 on every cycle in this state.
//   - !rd | !cs  -> IDLE with IRD=0 on the next cycle.
//   - rd&wr seen in READ or WRITE: set ErrFlag; no state change.
//   Status byte (addr 3) for the system read mux:
//   - {WrCount[5:0], TimeoutFlag, ErrFlag}.
//   Host requirement: DataBus held stable for >= SYNC_STAGES+1 CLK after WR_n rises.
//   Back-to-back cycles: a new cycle starts only from IDLE. Strobes still asserted on return to IDLE re-qualify normally.
//   Reset mid-cycle: abort immediately, no commit, IWR/IRD drop asynchronously.
// CONFIGURATION
//   BUS_CYCLE_TIMEOUT_EN defined:
//   - 8-bit cycle counter runs in WRITE/READ.
//   - At TIMEOUT_CYCLES: abort with no commit, set TimeoutFlag, -> WAIT_REL.
//   - WAIT_REL holds IWR=IRD=0 until !rd&!wr, then -> IDLE.
//   BUS_CYCLE_TIMEOUT_EN undefined:
//   - No counter and no WAIT_REL state; TimeoutFlag tied 0; cycles may last indefinitely.
// TESTING
//   1 Reset: RST=0 mid-WRITE -> IWR=0 at once; all outputs 0; Reg0..2 unchanged at 0 after release.
//   2 Write: A=2, WR_n low 6 cycles, InternalBus=8'hA5 -> COMMIT with WrStrobe=1 once; Reg2=8'hA5; WrCount=1.
//   3 Read: A=1, RD_n low 5 cycles -> RdStrobe=1 once; RdAddr=1; IRD high until 2 cycles after RD_n rises.
//   4 Conflict: CS_n, RD_n, WR_n all low -> ErrFlag=1, no IWR/IRD.
//     Then write addr 3 with 8'h01 -> ErrFlag=0.
//   5 Wrap: 256 writes to addr 0 -> WrCount returns to 0; last data present in Reg0.
//   6 (macro on, TIMEOUT_CYCLES=16) WR_n held low 40 cycles -> abort at cycle 16, TimeoutFlag=1, no WrStrobe.
//     WAIT_REL held until WR_n rises.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: host bus-cycle controller for the peripheral data-bus buffer.
//   Synchronizes the asynchronous host strobes and address, sequences
//   IDLE/WRITE/COMMIT/READ cycles, drives IWR/IRD to the bus buffer, commits
//   completed writes into a 3-entry register file and keeps a status byte.
//
// Optional feature: define BUS_CYCLE_TIMEOUT_EN to abort WRITE/READ cycles
// after TIMEOUT_CYCLES clocks (sets TimeoutFlag, waits in WAIT_REL for strobe
// release). Without it TimeoutFlag stays 0 and cycles may last indefinitely.
//
// Ports
//   CLK, RST            clock (rising edge), async active-low reset
//   CS_n, RD_n, WR_n, A host chip select / strobes / address (asynchronous)
//   InternalBus         byte captured by the bus buffer
//   IWR, IRD            buffer write / read enables
//   Reg0..Reg2          register file contents
//   WrStrobe            1-cycle pulse while a write commits
//   RdStrobe            1-cycle pulse at the start of a read cycle
//   RdAddr              address of the current read (valid while IRD=1)
//   ErrFlag             sticky RD_n+WR_n conflict flag
//   TimeoutFlag         sticky timeout-abort flag
//   WrCount             committed-write counter (wraps)
//   Status              address-3 read-back byte {WrCount[5:0], TimeoutFlag, ErrFlag}
module bus_cycle_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic [1:0] A,
  input  logic [7:0] InternalBus,
  output logic       IWR,
  output logic       IRD,
  output logic [7:0] Reg0,
  output logic [7:0] Reg1,
  output logic [7:0] Reg2,
  output logic       WrStrobe,
  output logic       RdStrobe,
  output logic [1:0] RdAddr,
  output logic       ErrFlag,
  output logic       TimeoutFlag,
  output logic [7:0] WrCount,
  output logic [7:0] Status
);

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
`ifdef BUS_CYCLE_TIMEOUT_EN
  localparam logic [2:0] S_WAIT_REL = 3'd4;
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
`endif

  // Elaboration-time parameter range checks
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("bus_cycle_ctrl: SYNC_STAGES must be 2..3");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("bus_cycle_ctrl: TIMEOUT_CYCLES must be 1..255");
  end

  // Input synchronizers: strobes idle high, address idles at 0
  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic [AW-1:0]          a_sync_q [SYNC_STAGES];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      for (int i = 0; i < int'(SYNC_STAGES); i++) a_sync_q[i] <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], RD_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], WR_n};
      a_sync_q[0] <= A;
      for (int i = 1; i < int'(SYNC_STAGES); i++) a_sync_q[i] <= a_sync_q[i-1];
    end
  end

  logic          cs, rd, wr;
  logic [AW-1:0] a_s;
  assign cs  = ~cs_sync_q[SYNC_STAGES-1];
  assign rd  = ~rd_sync_q[SYNC_STAGES-1];
  assign wr  = ~wr_sync_q[SYNC_STAGES-1];
  assign a_s = a_sync_q[SYNC_STAGES-1];

  // Architectural state
  logic [2:0]    state_q, state_d;
  logic          iwr_q, iwr_d, ird_q, ird_d;
  logic          wr_strobe_q, wr_strobe_d, rd_strobe_q, rd_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic          err_q, err_d, tmo_q, tmo_d;
  logic [DW-1:0] wr_count_q, wr_count_d;
  logic [DW-1:0] regs_q [3];
  logic [DW-1:0] regs_d [3];
`ifdef BUS_CYCLE_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      iwr_q       <= 1'b0;
      ird_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      wr_count_q  <= '0;
      for (int i = 0; i < 3; i++) regs_q[i] <= '0;
`ifdef BUS_CYCLE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      iwr_q       <= iwr_d;
      ird_q       <= ird_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      wr_count_q  <= wr_count_d;
      for (int i = 0; i < 3; i++) regs_q[i] <= regs_d[i];
`ifdef BUS_CYCLE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    rd_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    wr_count_d  = wr_count_q;
    for (int i = 0; i < 3; i++) regs_d[i] = regs_q[i];
`ifdef BUS_CYCLE_TIMEOUT_EN
    cnt_d       = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cs && rd && wr) begin
          err_d = 1'b1;
        end else if (cs && wr) begin
          state_d   = S_WRITE;
          wr_addr_d = a_s;
        end else if (cs && rd) begin
          state_d     = S_READ;
          rd_addr_d   = a_s;
          rd_strobe_d = 1'b1;
        end
      end

      S_WRITE: begin
        if (rd && wr) err_d = 1'b1;
        if (!wr || !cs) state_d = S_COMMIT;
`ifdef BUS_CYCLE_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = S_WAIT_REL;
          tmo_d   = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
`endif
      end

      // Data is taken at the end of COMMIT, after the strobe has been seen
      // released through the synchronizer, while the host still holds DataBus.
      S_COMMIT: begin
        case (wr_addr_q)
          2'd0: regs_d[0] = InternalBus;
          2'd1: regs_d[1] = InternalBus;
          2'd2: regs_d[2] = InternalBus;
          default: begin
            if (InternalBus[0]) err_d = 1'b0;
            if (InternalBus[1]) tmo_d = 1'b0;
          end
        endcase
        wr_count_d = wr_count_q + 8'd1;
        state_d    = S_IDLE;
      end

      S_READ: begin
        if (rd && wr) err_d = 1'b1;
        if (!rd || !cs) state_d = S_IDLE;
`ifdef BUS_CYCLE_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = S_WAIT_REL;
          tmo_d   = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
`endif
      end

`ifdef BUS_CYCLE_TIMEOUT_EN
      S_WAIT_REL: begin
        if (!rd && !wr) state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Enables and commit pulse track the next state so they align with it
    iwr_d       = (state_d == S_WRITE);
    ird_d       = (state_d == S_READ);
    wr_strobe_d = (state_d == S_COMMIT);
  end

  assign IWR         = iwr_q;
  assign IRD         = ird_q;
  assign WrStrobe    = wr_strobe_q;
  assign RdStrobe    = rd_strobe_q;
  assign RdAddr      = rd_addr_q;
  assign ErrFlag     = err_q;
  assign TimeoutFlag = tmo_q;
  assign WrCount     = wr_count_q;
  assign Reg0        = regs_q[0];
  assign Reg1        = regs_q[1];
  assign Reg2        = regs_q[2];
  assign Status      = {wr_count_q[5:0], tmo_q, err_q};

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl (SYNC_STAGES=2, TIMEOUT_CYCLES=16).
module tb_bus_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CS_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1;
  logic [1:0] A = 2'd0;
  logic [7:0] InternalBus = 8'd0;
  logic       IWR, IRD, WrStrobe, RdStrobe, ErrFlag, TimeoutFlag;
  logic [7:0] Reg0, Reg1, Reg2, WrCount, Status;
  logic [1:0] RdAddr;

  int checks = 0;
  int errors = 0;

  // Pulse / activity counters sampled on the clock
  int ws_cnt = 0, rs_cnt = 0, iwr_cyc = 0, act_cyc = 0;

  bus_cycle_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A),
    .InternalBus(InternalBus), .IWR(IWR), .IRD(IRD),
    .Reg0(Reg0), .Reg1(Reg1), .Reg2(Reg2),
    .WrStrobe(WrStrobe), .RdStrobe(RdStrobe), .RdAddr(RdAddr),
    .ErrFlag(ErrFlag), .TimeoutFlag(TimeoutFlag), .WrCount(WrCount),
    .Status(Status)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    ws_cnt  <= ws_cnt  + (WrStrobe ? 1 : 0);
    rs_cnt  <= rs_cnt  + (RdStrobe ? 1 : 0);
    iwr_cyc <= iwr_cyc + (IWR ? 1 : 0);
    act_cyc <= act_cyc + ((IWR || IRD) ? 1 : 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    A = addr; InternalBus = data; CS_n = 1'b0; WR_n = 1'b0;
    tick(4);
    WR_n = 1'b1; CS_n = 1'b1;
    tick(5);
  endtask

  int ws0, rs0, iw0, ac0;
  logic [7:0] last_d, prev_d;

  initial begin
    // 1: reset values, then reset in the middle of a write
    tick(3);
    chk("rst_iwr", 32'(IWR), 32'd0);
    chk("rst_ird", 32'(IRD), 32'd0);
    chk("rst_reg0", 32'(Reg0), 32'd0);
    chk("rst_reg1", 32'(Reg1), 32'd0);
    chk("rst_reg2", 32'(Reg2), 32'd0);
    chk("rst_wrs", 32'(WrStrobe), 32'd0);
    chk("rst_rds", 32'(RdStrobe), 32'd0);
    chk("rst_rdaddr", 32'(RdAddr), 32'd0);
    chk("rst_err", 32'(ErrFlag), 32'd0);
    chk("rst_tmo", 32'(TimeoutFlag), 32'd0);
    chk("rst_wrcount", 32'(WrCount), 32'd0);
    chk("rst_status", 32'(Status), 32'd0);
    RST = 1'b1;
    tick(2);

    ws0 = ws_cnt;
    A = 2'd1; InternalBus = 8'h5A; CS_n = 1'b0; WR_n = 1'b0;
    tick(5);
    chk("midwr_iwr_on", 32'(IWR), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("midwr_iwr_async_off", 32'(IWR), 32'd0);
    WR_n = 1'b1; CS_n = 1'b1;
    tick(2);
    RST = 1'b1;
    tick(6);
    chk("midwr_reg1", 32'(Reg1), 32'd0);
    chk("midwr_wrcount", 32'(WrCount), 32'd0);
    chk("midwr_no_strobe", 32'(ws_cnt - ws0), 32'd0);

    // 2: write 0xA5 to address 2
    ws0 = ws_cnt;
    A = 2'd2; InternalBus = 8'hA5; CS_n = 1'b0; WR_n = 1'b0;
    tick(6);
    chk("wr_iwr", 32'(IWR), 32'd1);
    WR_n = 1'b1; CS_n = 1'b1;
    tick(6);
    chk("wr_strobe_once", 32'(ws_cnt - ws0), 32'd1);
    chk("wr_reg2", 32'(Reg2), 32'hA5);
    chk("wr_wrcount", 32'(WrCount), 32'd1);
    chk("wr_iwr_off", 32'(IWR), 32'd0);

    // 3: read address 1
    rs0 = rs_cnt;
    A = 2'd1; CS_n = 1'b0; RD_n = 1'b0;
    tick(5);
    chk("rd_ird", 32'(IRD), 32'd1);
    chk("rd_addr", 32'(RdAddr), 32'd1);
    chk("rd_strobe_once", 32'(rs_cnt - rs0), 32'd1);
    RD_n = 1'b1; CS_n = 1'b1;
    tick(2);
    chk("rd_ird_hold", 32'(IRD), 32'd1);
    tick(2);
    chk("rd_ird_off", 32'(IRD), 32'd0);
    chk("rd_strobe_total", 32'(rs_cnt - rs0), 32'd1);

    // 4: RD/WR conflict, then clear through address 3
    ac0 = act_cyc;
    A = 2'd0; CS_n = 1'b0; RD_n = 1'b0; WR_n = 1'b0;
    tick(6);
    chk("cf_err", 32'(ErrFlag), 32'd1);
    chk("cf_no_enable", 32'(act_cyc - ac0), 32'd0);
    chk("cf_status", 32'(Status), 32'h05);
    CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    tick(4);
    do_write(2'd3, 8'h01);
    chk("cf_err_clr", 32'(ErrFlag), 32'd0);
    chk("cf_wrcount", 32'(WrCount), 32'd2);
    chk("cf_status2", 32'(Status), 32'h08);
    chk("cf_reg0_untouched", 32'(Reg0), 32'd0);

    // 5: counter wrap after 256 writes to address 0
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    tick(2);
    ws0 = ws_cnt;
    prev_d = 8'd0; last_d = 8'd0;
    for (int i = 0; i < 256; i++) begin
      prev_d = last_d;
      last_d = 8'(i * 3 + 1);
      do_write(2'd0, last_d);
      if (i == 254) begin
        chk("wrap_count_255", 32'(WrCount), 32'd255);
        chk("wrap_reg0_255", 32'(Reg0), 32'(last_d));
      end
    end
    chk("wrap_count_0", 32'(WrCount), 32'd0);
    chk("wrap_reg0_last", 32'(Reg0), 32'hFE);
    chk("wrap_strobes", 32'(ws_cnt - ws0), 32'd256);

    // 6: long write strobe
    ws0 = ws_cnt;
    iw0 = iwr_cyc;
    A = 2'd1; InternalBus = 8'h3C; CS_n = 1'b0; WR_n = 1'b0;
    tick(43);
`ifdef BUS_CYCLE_TIMEOUT_EN
    chk("tmo_flag", 32'(TimeoutFlag), 32'd1);
    chk("tmo_iwr_off", 32'(IWR), 32'd0);
    chk("tmo_iwr_cycles", 32'(iwr_cyc - iw0), 32'd16);
    chk("tmo_no_strobe", 32'(ws_cnt - ws0), 32'd0);
    chk("tmo_status", 32'(Status), 32'h02);
    WR_n = 1'b1; CS_n = 1'b1;
    tick(5);
    chk("tmo_no_commit", 32'(Reg1), 32'd0);
    do_write(2'd3, 8'h02);
    chk("tmo_clr", 32'(TimeoutFlag), 32'd0);
    chk("tmo_clr_strobe", 32'(ws_cnt - ws0), 32'd1);
`else
    chk("long_iwr_on", 32'(IWR), 32'd1);
    chk("long_tmo_zero", 32'(TimeoutFlag), 32'd0);
    WR_n = 1'b1; CS_n = 1'b1;
    tick(6);
    chk("long_commit", 32'(ws_cnt - ws0), 32'd1);
    chk("long_reg1", 32'(Reg1), 32'h3C);
    chk("long_wrcount", 32'(WrCount), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
